// File: rtl/adc_emu_pkg.sv
// Shared frame constants, FSM encoding and LFSR/dither helpers for the ADC128S022 emulator.
// The dither helpers are only referenced when ADC_EMU_DITHER_EN is defined.
package adc_emu_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_FIRST = 1;
    localparam int ADDR_LAST  = 3;
    localparam int DATA_FIRST = 4;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        TAIL = 2'd3
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask on bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = ^(cur & LFSR_TAPS);
        return {cur[14:0], fb};
    endfunction

    // Adds a signed -4..+3 offset and clamps to the 12-bit code range
    function automatic logic [11:0] dither_sat(input logic [11:0] raw, input logic [2:0] off);
        logic signed [13:0] sum;
        sum = $signed({2'b00, raw}) + $signed({{11{off[2]}}, off});
        if (sum < 14'sd0) begin
            return 12'd0;
        end else if (sum > 14'sd4095) begin
            return 12'd4095;
        end else begin
            return sum[11:0];
        end
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizer chain for one asynchronous SPI line plus registered rise/fall pulses.
// The sync output is delayed to line up with the pulses so all lines share one timing.
module spi_in_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;
    logic              rise_r;
    logic              fall_r;

    // Metastability chain followed by edge detection on the settled value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain_r <= {STAGES{1'b0}};
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], din};
            prev_r  <= chain_r[STAGES-1];
            rise_r  <= chain_r[STAGES-1] & ~prev_r;
            fall_r  <= ~chain_r[STAGES-1] & prev_r;
        end
    end

    assign sync = prev_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/adc128s022_emu.sv
// SPI responder emulating an ADC128S022: the address sent in one frame selects the data of the next.
// Optional build macro ADC_EMU_DITHER_EN adds LFSR dither (-4..+3, saturated) to every snapshot.
module adc128s022_emu
    import adc_emu_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   SPI_SCK,
    input  logic                   SPI_AD,
    input  logic                   SPI_DIN,
    output logic                   SPI_DOUT,
    input  logic [N_CH*DATA_W-1:0] CH_DATA,
    output logic                   FRAME_DONE,
    output logic                   FRAME_ERR,
    output logic [2:0]             LAST_ADDR
);

    logic sck_sync_s, sck_rise_s, sck_fall_s;
    logic cs_sync_s, cs_rise_s, cs_fall_s;
    logic din_sync_s, din_rise_s, din_fall_s;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(CLK), .rst_n(RST_N), .din(SPI_SCK), .sync(sck_sync_s), .rise(sck_rise_s), .fall(sck_fall_s)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(CLK), .rst_n(RST_N), .din(SPI_AD), .sync(cs_sync_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );
    spi_in_sync #(.STAGES(SYNC_STAGES)) u_din_sync (
        .clk(CLK), .rst_n(RST_N), .din(SPI_DIN), .sync(din_sync_s), .rise(din_rise_s), .fall(din_fall_s)
    );

    logic unused_s;
    assign unused_s = ^{sck_sync_s, sck_rise_s, cs_sync_s, din_rise_s, din_fall_s};

    state_t                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        bit_cnt_r, bit_cnt_nxt_s;
    logic [FRAME_BITS-1:0]   shreg_r, shreg_nxt_s;
    logic [1:0]              addr_hi_r, addr_hi_nxt_s;
    logic [2:0]              next_addr_r, next_addr_nxt_s;
    logic [2:0]              last_addr_r, last_addr_nxt_s;
    logic                    dout_r, dout_nxt_s;
    logic                    done_r, done_nxt_s;
    logic                    err_r, err_nxt_s;
    logic [DATA_W-1:0]       raw_s;
    logic [DATA_W-1:0]       snap_s;
    logic [3:0]              dout_idx_s;

    assign dout_idx_s = 4'(FRAME_BITS - 1) - bit_cnt_r[3:0];

`ifdef ADC_EMU_DITHER_EN
    logic [15:0] lfsr_r;

    // Dither sequence steps once per frame, at the chip-select fall
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lfsr_r <= LFSR_SEED;
        end else if (cs_fall_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`endif

    // Channel mux for the frame snapshot; unpopulated addresses read as zero
    always_comb begin
        raw_s = {DATA_W{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            if (next_addr_r == 3'(k)) begin
                raw_s = CH_DATA[k*DATA_W +: DATA_W];
            end else begin
                raw_s = raw_s;
            end
        end
`ifdef ADC_EMU_DITHER_EN
        snap_s = dither_sat(raw_s, lfsr_r[2:0]);
`else
        snap_s = raw_s;
`endif
    end

    // Frame FSM next-state: CS edges take priority over any SCK edge in the same cycle
    always_comb begin
        state_nxt_s     = state_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shreg_nxt_s     = shreg_r;
        addr_hi_nxt_s   = addr_hi_r;
        next_addr_nxt_s = next_addr_r;
        last_addr_nxt_s = last_addr_r;
        dout_nxt_s      = dout_r;
        done_nxt_s      = 1'b0;
        err_nxt_s       = 1'b0;
        if (cs_rise_s) begin
            state_nxt_s = IDLE;
            dout_nxt_s  = 1'b0;
            if (state_r != IDLE) begin
                if (bit_cnt_r == CNT_FULL) begin
                    done_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = 1'b1;
                end
            end else begin
                done_nxt_s = 1'b0;
            end
        end else if (cs_fall_s) begin
            state_nxt_s   = ADDR;
            bit_cnt_nxt_s = {CNT_W{1'b0}};
            shreg_nxt_s   = FRAME_BITS'(snap_s);
            addr_hi_nxt_s = 2'b00;
            dout_nxt_s    = 1'b0;
        end else if (sck_fall_s) begin
            case (state_r)
                ADDR, DATA: begin
                    if (bit_cnt_r == CNT_W'(ADDR_FIRST)) begin
                        addr_hi_nxt_s[1] = din_sync_s;
                    end else if (bit_cnt_r == CNT_W'(ADDR_FIRST + 1)) begin
                        addr_hi_nxt_s[0] = din_sync_s;
                    end else if (bit_cnt_r == CNT_W'(ADDR_LAST)) begin
                        next_addr_nxt_s = {addr_hi_r, din_sync_s};
                        last_addr_nxt_s = {addr_hi_r, din_sync_s};
                    end else begin
                        next_addr_nxt_s = next_addr_r;
                    end
                    if (bit_cnt_r >= CNT_W'(DATA_FIRST)) begin
                        dout_nxt_s = shreg_r[dout_idx_s];
                    end else begin
                        dout_nxt_s = 1'b0;
                    end
                    bit_cnt_nxt_s = bit_cnt_r + 5'd1;
                    if (bit_cnt_nxt_s == CNT_FULL) begin
                        state_nxt_s = TAIL;
                    end else if (bit_cnt_nxt_s >= CNT_W'(DATA_FIRST)) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = ADDR;
                    end
                end
                TAIL: begin
                    dout_nxt_s = 1'b0;
                end
                default: begin
                    dout_nxt_s = 1'b0;
                end
            endcase
        end else begin
            dout_nxt_s = dout_r;
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r     <= IDLE;
            bit_cnt_r   <= {CNT_W{1'b0}};
            shreg_r     <= {FRAME_BITS{1'b0}};
            addr_hi_r   <= 2'b00;
            next_addr_r <= 3'd0;
            last_addr_r <= 3'd0;
            dout_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shreg_r     <= shreg_nxt_s;
            addr_hi_r   <= addr_hi_nxt_s;
            next_addr_r <= next_addr_nxt_s;
            last_addr_r <= last_addr_nxt_s;
            dout_r      <= dout_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    assign SPI_DOUT   = dout_r;
    assign FRAME_DONE = done_r;
    assign FRAME_ERR  = err_r;
    assign LAST_ADDR  = last_addr_r;

endmodule

// File: tb/tb_adc128s022_emu.sv
// Randomized self-checking bench for adc128s022_emu against a frame-level reference model.
// With ADC_EMU_DITHER_EN defined, returned codes are checked against the dither window instead.
module tb_adc128s022_emu;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        SPI_SCK;
    logic        SPI_AD;
    logic        SPI_DIN;
    logic        SPI_DOUT;
    logic [95:0] CH_DATA;
    logic        FRAME_DONE;
    logic        FRAME_ERR;
    logic [2:0]  LAST_ADDR;

    adc128s022_emu dut (
        .CLK(CLK), .RST_N(RST_N), .SPI_SCK(SPI_SCK), .SPI_AD(SPI_AD), .SPI_DIN(SPI_DIN),
        .SPI_DOUT(SPI_DOUT), .CH_DATA(CH_DATA), .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR),
        .LAST_ADDR(LAST_ADDR)
    );

    always #10 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int ch_model[8];
    int model_next = 0;
    int model_last = 0;
    int mid_edge = -1;
    int mid_val = 0;

    always @(negedge CLK) begin
        if (FRAME_DONE === 1'b1) done_cnt++;
        if (FRAME_ERR === 1'b1) err_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_ch(input int k, input int v);
        ch_model[k] = v;
        CH_DATA[k*12 +: 12] = 12'(v);
    endtask

    // One SCK period (idle high): DIN set up, falling edge, DOUT sampled well after it
    task automatic sck_edge(input logic d, output logic q);
        SPI_DIN = d;
        clks(5);
        SPI_SCK = 1'b0;
        clks(8);
        q = SPI_DOUT;
        SPI_SCK = 1'b1;
        clks(7);
    endtask

    task automatic check_code(input string tag, input int got, input int exp);
`ifdef ADC_EMU_DITHER_EN
        int lo, hi;
        lo = (exp < 4) ? 0 : exp - 4;
        hi = (exp > 4092) ? 4095 : exp + 3;
        check_val(tag, (got >= lo && got <= hi), 1);
`else
        check_val(tag, got, exp);
`endif
    endtask

    task automatic frame(input int addr, input int n_edges, input string tag);
        int   exp, word, bad, d0, e0;
        logic d, q;
        exp  = ch_model[model_next];
        d0   = done_cnt;
        e0   = err_cnt;
        word = 0;
        bad  = 0;
        SPI_AD = 1'b0;
        clks(10);
        for (int i = 0; i < n_edges; i++) begin
            if (i == mid_edge) set_ch(0, mid_val);
            case (i)
                1: d = addr[2];
                2: d = addr[1];
                3: d = addr[0];
                default: d = 1'($urandom_range(0, 1));
            endcase
            sck_edge(d, q);
            if (i >= 4 && i < 16) begin
                word = (word << 1) | int'(q);
            end else if (q !== 1'b0) begin
                bad++;
            end
        end
        clks(5);
        SPI_AD = 1'b1;
        clks(12);
        if (n_edges >= 4) begin
            model_next = addr;
            model_last = addr;
        end
        check_val({tag, "_dout_idle"}, SPI_DOUT, 0);
        check_val({tag, "_nondata_zero"}, bad, 0);
        check_val({tag, "_last_addr"}, LAST_ADDR, model_last);
        check_val({tag, "_done"}, done_cnt - d0, (n_edges >= 16) ? 1 : 0);
        check_val({tag, "_err"}, err_cnt - e0, (n_edges >= 16) ? 0 : 1);
        if (n_edges >= 16) check_code({tag, "_data"}, word, exp);
    endtask

    initial begin
        int   d0, e0, bad, n;
        logic q;
        RST_N = 1'b0;
        SPI_SCK = 1'b1;
        SPI_AD = 1'b1;
        SPI_DIN = 1'b0;
        CH_DATA = 96'd0;
        for (int k = 0; k < 8; k++) ch_model[k] = 0;
        clks(5);
        RST_N = 1'b1;
        clks(5);
        check_val("rst_dout", SPI_DOUT, 0);
        check_val("rst_done", FRAME_DONE, 0);
        check_val("rst_err", FRAME_ERR, 0);
        check_val("rst_last_addr", LAST_ADDR, 0);

        // Pipelined address: frame N's address picks frame N+1's data
        d0 = done_cnt;
        set_ch(1, 2000);
        mid_edge = 2;
        mid_val = 1000;
        frame(0, 16, "f1");
        mid_edge = -1;
        frame(1, 16, "f2");
        frame(5, 16, "f3");
        check_val("three_done", done_cnt - d0, 3);

        // Aborted frame after 8 edges still updates the address
        frame(3, 8, "abort");
        set_ch(3, 777);
        frame(0, 16, "after_abort");

        // Snapshot at CS fall survives a mid-frame change
        set_ch(0, 4095);
        mid_edge = 6;
        mid_val = 0;
        frame(0, 16, "snap");
        mid_edge = -1;

        // Reset mid-frame with CS held low
        set_ch(2, 321);
        frame(2, 16, "pre_rst");
        d0 = done_cnt;
        e0 = err_cnt;
        bad = 0;
        SPI_AD = 1'b0;
        clks(10);
        for (int i = 0; i < 8; i++) sck_edge(1'b1, q);
        RST_N = 1'b0;
        clks(2);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sck_edge(1'b1, q);
            if (q !== 1'b0) bad++;
        end
        clks(5);
        SPI_AD = 1'b1;
        clks(12);
        model_next = 0;
        model_last = 0;
        check_val("rst_mid_dout_zero", bad, 0);
        check_val("rst_mid_last_addr", LAST_ADDR, 0);
        check_val("rst_mid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
        set_ch(0, 1234);
        frame(6, 16, "post_rst");

        // Extra SCK edges past 16 are ignored
        frame(4, 20, "long");

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            for (int k = 0; k < 8; k++) set_ch(k, int'($urandom_range(0, 4095)));
            case ($urandom_range(0, 4))
                0: n = 20;
                1: n = int'($urandom_range(1, 15));
                default: n = 16;
            endcase
            frame(int'($urandom_range(0, 7)), n, $sformatf("rnd%0d", f));
        end

        // Near-full-scale code, exact without dither and windowed with it
        set_ch(0, 4094);
        frame(0, 16, "fs_prime");
        for (int f = 0; f < 4; f++) frame(0, 16, $sformatf("fs%0d", f));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
